// File: rtl/mat_mult_operand_streamer_if.sv
// Operand-streamer <-> systolic array handshake bundle.
// Signal names match the array's own ports so a slave-side adapter can
// connect them by name. Each a_in/b_in lane is an 8-bit two's-complement value;
// lane j occupies bits [8*j +: 8].
interface mat_mult_operand_streamer_if;
    logic             ready;
    logic             start;
    logic             done;
    logic             a_valid;
    logic             a_ready;
    logic [7:0][7:0]  a_in;
    logic             b_valid;
    logic             b_ready;
    logic [7:0][7:0]  b_in;

    modport master (
        input  ready,
        input  done,
        input  a_ready,
        input  b_ready,
        output start,
        output a_valid,
        output a_in,
        output b_valid,
        output b_in
    );

    modport slave (
        output ready,
        output done,
        output a_ready,
        output b_ready,
        input  start,
        input  a_valid,
        input  a_in,
        input  b_valid,
        input  b_in
    );
endinterface

// File: rtl/mat_mult_operand_streamer.sv
// Buffers two 8x8 signed-byte operand matrices (A, B) and streams them to a
// systolic array as eight 8-lane beats per operand.
//
// Beat k carries column k of A (a_in[j] = A[j][k]). For B, the default build
// carries column k (b_in[j] = B[j][k]); defining STREAMER_TRANSPOSE_B_EN
// switches B to row k (b_in[j] = B[k][j]).
//
// State        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | waiting for go with array ready; buffers writable
// ST_START     | one-cycle start pulse to the array
// ST_STREAM    | A and B beats flowing, each under its own valid/ready
// ST_WAIT_DONE | all 16 beats sent, waiting for the array's done
module mat_mult_operand_streamer (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic                               wr_sel,
    input  logic [5:0]                         wr_addr,
    input  logic signed [7:0]                  wr_data,
    output logic                               wr_err,
    input  logic                               go,
    output logic                               busy,
    output logic                               job_done,
    mat_mult_operand_streamer_if.master        arr
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_STREAM    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            a_valid_q, a_valid_d;
    logic            b_valid_q, b_valid_d;
    logic [2:0]      a_k_q, a_k_d;
    logic [2:0]      b_k_q, b_k_d;
    logic            job_done_q, job_done_d;
    logic            wr_err_q, wr_err_d;

    logic            start_c;
    logic            busy_c;
    logic            wr_accept;
    logic [7:0][7:0] a_lanes;
    logic [7:0][7:0] b_lanes;

    // Operand buffers, indexed row*8 + col; deliberately not reset so a job
    // after reset reuses what was loaded before it.
    logic signed [7:0] a_mem_q [64];
    logic signed [7:0] b_mem_q [64];

    assign busy_c    = (state_q != ST_IDLE);
    assign wr_accept = wr_en && !busy_c;

    // Buffer write port: only accepted while no job owns the buffers.
    always_ff @(posedge clk) begin
        if (wr_accept && !wr_sel) begin
            a_mem_q[wr_addr] <= wr_data;
        end
        if (wr_accept && wr_sel) begin
            b_mem_q[wr_addr] <= wr_data;
        end
    end

    // Next-state, beat counters and pulse outputs.
    always_comb begin
        state_d    = state_q;
        a_valid_d  = a_valid_q;
        b_valid_d  = b_valid_q;
        a_k_d      = a_k_q;
        b_k_d      = b_k_q;
        job_done_d = 1'b0;
        wr_err_d   = wr_en && busy_c;
        start_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // job_done_q blocks a go that arrives alongside the completion
                // pulse, so the array sees a clean gap between jobs.
                if (go && arr.ready && !job_done_q) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                start_c   = 1'b1;
                state_d   = ST_STREAM;
                a_valid_d = 1'b1;
                b_valid_d = 1'b1;
                a_k_d     = 3'd0;
                b_k_d     = 3'd0;
            end

            ST_STREAM: begin
                if (a_valid_q && arr.a_ready) begin
                    a_k_d = a_k_q + 3'd1;
                    if (a_k_q == 3'd7) begin
                        a_valid_d = 1'b0;
                    end
                end
                if (b_valid_q && arr.b_ready) begin
                    b_k_d = b_k_q + 3'd1;
                    if (b_k_q == 3'd7) begin
                        b_valid_d = 1'b0;
                    end
                end
                // A stream with valid low inside STREAM has already sent beat 7.
                if (!a_valid_d && !b_valid_d) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (arr.done) begin
                    state_d    = ST_IDLE;
                    job_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and handshake registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            a_k_q      <= 3'd0;
            b_k_q      <= 3'd0;
            job_done_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            a_k_q      <= a_k_d;
            b_k_q      <= b_k_d;
            job_done_q <= job_done_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Beat data: read straight from the buffers at the current beat index,
    // zeroed whenever the stream is not presenting a beat. The index only moves
    // on a transfer, so data holds while stalled.
    always_comb begin
        a_lanes = '0;
        b_lanes = '0;
        for (int j = 0; j < 8; j++) begin
            if (a_valid_q) begin
                a_lanes[j] = a_mem_q[{3'(j), a_k_q}];
            end
            if (b_valid_q) begin
`ifdef STREAMER_TRANSPOSE_B_EN
                b_lanes[j] = b_mem_q[{b_k_q, 3'(j)}];
`else
                b_lanes[j] = b_mem_q[{3'(j), b_k_q}];
`endif
            end
        end
    end

    assign arr.start   = start_c;
    assign arr.a_valid = a_valid_q;
    assign arr.b_valid = b_valid_q;
    assign arr.a_in    = a_lanes;
    assign arr.b_in    = b_lanes;
    assign busy        = busy_c;
    assign job_done    = job_done_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_mat_mult_operand_streamer.sv
// Directed bench for mat_mult_operand_streamer.
module tb_mat_mult_operand_streamer;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic              wr_sel;
    logic [5:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic              wr_err;
    logic              go;
    logic              busy;
    logic              job_done;

    int checks;
    int errors;

    logic [7:0] a_model [64];
    logic [7:0] b_model [64];

    mat_mult_operand_streamer_if arr_if ();

    mat_mult_operand_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .go       (go),
        .busy     (busy),
        .job_done (job_done),
        .arr      (arr_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0][7:0] exp_a(input int k);
        logic [7:0][7:0] r;
        for (int j = 0; j < 8; j++) r[j] = a_model[j*8 + k];
        return r;
    endfunction

    function automatic logic [7:0][7:0] exp_b(input int k);
        logic [7:0][7:0] r;
        for (int j = 0; j < 8; j++) begin
`ifdef STREAMER_TRANSPOSE_B_EN
            r[j] = b_model[k*8 + j];
`else
            r[j] = b_model[j*8 + k];
`endif
        end
        return r;
    endfunction

    task automatic write_elem(input logic sel, input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 6'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (sel) b_model[addr] = data;
        else     a_model[addr] = data;
    endtask

    // go pulse; returns in the first STREAM cycle (beat 0 presented)
    task automatic start_job();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
    endtask

    // from STREAM cycle 0 with both readies high: run beats, finish with done
    task automatic drain_job();
        repeat (8) tick();
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, arr_if.start, arr_if.a_valid, arr_if.b_valid, job_done, wr_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {busy, arr_if.start, arr_if.a_valid, arr_if.b_valid, job_done, wr_err});
        end
        checks++;
        if (arr_if.a_in !== 64'h0 || arr_if.b_in !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h want 0", arr_if.a_in, arr_if.b_in);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        for (int i = 0; i < 64; i++) write_elem(1'b0, i, 8'(i));
        for (int i = 0; i < 64; i++) write_elem(1'b1, i, ((i / 8) == (i % 8)) ? 8'd1 : 8'd0);
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_wr_err got %b want 0", wr_err);
        end
    endtask

    task automatic test_basic_stream();
        logic [7:0][7:0] beat3_a;
        logic [7:0][7:0] beat3_b;
        beat3_a = {8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3};
        beat3_b = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
        arr_if.a_ready = 1'b1;
        arr_if.b_ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (arr_if.start !== 1'b1 || busy !== 1'b1 || arr_if.a_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle got start=%b busy=%b a_valid=%b want 1 1 0",
                     arr_if.start, busy, arr_if.a_valid);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (arr_if.a_valid !== 1'b1 || arr_if.b_valid !== 1'b1 || arr_if.start !== 1'b0 ||
                arr_if.a_in !== exp_a(k) || arr_if.b_in !== exp_b(k)) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b%b a=%h b=%h want 11 a=%h b=%h", k,
                         arr_if.a_valid, arr_if.b_valid, arr_if.a_in, arr_if.b_in, exp_a(k), exp_b(k));
            end
            if (k == 3) begin
                checks++;
                if (arr_if.a_in !== beat3_a || arr_if.b_in !== beat3_b) begin
                    errors++;
                    $display("FAIL basic_beat3_hand got a=%h b=%h want a=%h b=%h",
                             arr_if.a_in, arr_if.b_in, beat3_a, beat3_b);
                end
            end
            tick();
        end
        checks++;
        if (arr_if.a_valid !== 1'b0 || arr_if.b_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_after_beats got v=%b%b busy=%b want 00 1",
                     arr_if.a_valid, arr_if.b_valid, busy);
        end
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        checks++;
        if (job_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_job_done got job_done=%b busy=%b want 1 0", job_done, busy);
        end
        tick();
        checks++;
        if (job_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_job_done_pulse got %b want 0", job_done);
        end
    endtask

    task automatic test_backpressure();
        int         ak;
        int         bk;
        logic       av;
        logic       bv;
        logic       arq;
        ak = 0; bk = 0; av = 1'b1; bv = 1'b1;
        arr_if.a_ready = 1'b1;
        arr_if.b_ready = 1'b1;
        start_job();
        for (int cyc = 0; cyc < 12; cyc++) begin
            arq = !(cyc >= 2 && cyc <= 4);
            arr_if.a_ready = arq;
            arr_if.done    = (cyc == 9);
            checks++;
            if (arr_if.a_valid !== av || arr_if.b_valid !== bv || job_done !== 1'b0 || busy !== 1'b1 ||
                (av && arr_if.a_in !== exp_a(ak)) || (bv && arr_if.b_in !== exp_b(bk))) begin
                errors++;
                $display("FAIL bp_cyc%0d got v=%b%b jd=%b busy=%b a=%h b=%h want v=%b%b jd=0 busy=1 a=%h b=%h",
                         cyc, arr_if.a_valid, arr_if.b_valid, job_done, busy, arr_if.a_in, arr_if.b_in,
                         av, bv, exp_a(ak), exp_b(bk));
            end
            tick();
            if (av && arq) begin
                if (ak == 7) av = 1'b0;
                ak = (ak + 1) % 8;
            end
            if (bv) begin
                if (bk == 7) bv = 1'b0;
                bk = (bk + 1) % 8;
            end
        end
        arr_if.a_ready = 1'b1;
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        checks++;
        if (job_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_job_done got job_done=%b busy=%b want 1 0", job_done, busy);
        end
        tick();
    endtask

    task automatic test_wr_err();
        arr_if.a_ready = 1'b1;
        arr_if.b_ready = 1'b1;
        start_job();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd5; wr_data = -8'sd7;
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_err_pulse got %b want 1", wr_err);
        end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_single got %b want 0", wr_err);
        end
        repeat (6) tick();
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        tick();
        start_job();
        repeat (5) tick();
        checks++;
        if (arr_if.a_in[0] !== 8'd5) begin
            errors++;
            $display("FAIL wr_drop_a05 got %0d want 5", arr_if.a_in[0]);
        end
        repeat (3) tick();
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        tick();
    endtask

    task automatic test_go_ready();
        logic saw_start;
        arr_if.a_ready = 1'b1;
        arr_if.b_ready = 1'b1;
        arr_if.ready = 1'b0;
        go = 1'b1;
        tick();
        tick();
        checks++;
        if (arr_if.start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL go_not_ready got start=%b busy=%b want 0 0", arr_if.start, busy);
        end
        arr_if.ready = 1'b1;
        tick();
        checks++;
        if (arr_if.start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL go_ready got start=%b busy=%b want 1 1", arr_if.start, busy);
        end
        tick();
        saw_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (arr_if.start) saw_start = 1'b1;
        end
        go = 1'b0;
        checks++;
        if (saw_start !== 1'b0 || arr_if.a_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL go_while_busy got restart=%b a_valid=%b busy=%b want 0 0 1",
                     saw_start, arr_if.a_valid, busy);
        end
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        checks++;
        if (job_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_in_wait got job_done=%b busy=%b want 1 0", job_done, busy);
        end
        go = 1'b1;
        tick();
        checks++;
        if (arr_if.start !== 1'b0 || busy !== 1'b0 || job_done !== 1'b0) begin
            errors++;
            $display("FAIL go_with_job_done got start=%b busy=%b jd=%b want 0 0 0",
                     arr_if.start, busy, job_done);
        end
        tick();
        go = 1'b0;
        checks++;
        if (arr_if.start !== 1'b1) begin
            errors++;
            $display("FAIL go_after_job_done got start=%b want 1", arr_if.start);
        end
        tick();
        drain_job();
    endtask

    task automatic test_reset_mid_stream();
        arr_if.a_ready = 1'b1;
        arr_if.b_ready = 1'b1;
        start_job();
        repeat (4) tick();
        checks++;
        if (arr_if.a_in !== exp_a(4) || arr_if.a_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat4 got a=%h v=%b want a=%h v=1", arr_if.a_in, arr_if.a_valid, exp_a(4));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (arr_if.a_valid !== 1'b0 || arr_if.b_valid !== 1'b0 || busy !== 1'b0 ||
            arr_if.a_in !== 64'h0 || arr_if.b_in !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b%b busy=%b a=%h b=%h want 00 0 0 0",
                     arr_if.a_valid, arr_if.b_valid, busy, arr_if.a_in, arr_if.b_in);
        end
        tick();
        start_job();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (arr_if.a_valid !== 1'b1 || arr_if.a_in !== exp_a(k) || arr_if.b_in !== exp_b(k)) begin
                errors++;
                $display("FAIL restart_beat%0d got a=%h b=%h want a=%h b=%h",
                         k, arr_if.a_in, arr_if.b_in, exp_a(k), exp_b(k));
            end
            tick();
        end
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        tick();
    endtask

    task automatic test_b_mapping();
        logic [7:0][7:0] beat2_b;
`ifdef STREAMER_TRANSPOSE_B_EN
        beat2_b = {8'd23, 8'd22, 8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd16};
`else
        beat2_b = {8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2};
`endif
        for (int i = 0; i < 64; i++) write_elem(1'b1, i, 8'(i));
        arr_if.a_ready = 1'b1;
        arr_if.b_ready = 1'b1;
        start_job();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (arr_if.b_valid !== 1'b1 || arr_if.b_in !== exp_b(k) || arr_if.a_in !== exp_a(k)) begin
                errors++;
                $display("FAIL bmap_beat%0d got a=%h b=%h want a=%h b=%h",
                         k, arr_if.a_in, arr_if.b_in, exp_a(k), exp_b(k));
            end
            if (k == 2) begin
                checks++;
                if (arr_if.b_in !== beat2_b) begin
                    errors++;
                    $display("FAIL bmap_beat2_hand got %h want %h", arr_if.b_in, beat2_b);
                end
            end
            tick();
        end
        arr_if.done = 1'b1;
        tick();
        arr_if.done = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 8'sd0;
        go = 1'b0;
        arr_if.ready = 1'b1;
        arr_if.done = 1'b0;
        arr_if.a_ready = 1'b0;
        arr_if.b_ready = 1'b0;
        #1;
        test_reset();
        test_load();
        test_basic_stream();
        test_backpressure();
        test_wr_err();
        test_go_ready();
        test_reset_mid_stream();
        test_b_mapping();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
